axi_addr_remap_ctrl: RTL and testbench
======================================

# axi_addr_remap_ctrl

Runtime-configurable address-remap controller that generates the master-side AW and AR addresses for an AXI address-modification stage. It sits beside that stage: it observes the slave-port AW/AR address and handshake, translates the address through a small rule table, and holds the result stable until the master-port handshake completes. A configuration port updates the table, and updates are admitted only while no address handshake is pending.

## Interface
- NumRules, 4: number of remap rules, 1..16.
- SlvAddrWidth, 32: slave-port address width.
- MstAddrWidth, 32: master-port address width.
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- slv_aw_addr_i  in  SlvAddrWidth  slave-port AW address.
- slv_aw_valid_i  in  1  slave-port AW valid.
- mst_aw_ready_i  in  1  master-port AW ready.
- mst_aw_addr_o  out  MstAddrWidth  translated AW address.
- aw_miss_o  out  1  current AW address hit no enabled rule.
- slv_ar_addr_i, slv_ar_valid_i, mst_ar_ready_i, mst_ar_addr_o, ar_miss_o: same as the AW set, for the AR channel.
- cfg_valid_i  in  1  configuration write request.
- cfg_ready_o  out  1  configuration write accepted this cycle.
- cfg_idx_i  in  $clog2(NumRules) (min 1)  rule index.
- cfg_en_i  in  1  rule enable.
- cfg_base_i  in  SlvAddrWidth  match base.
- cfg_mask_i  in  SlvAddrWidth  pass-through mask; 1 = bit copied from the slave address.
- cfg_target_i  in  MstAddrWidth  replacement bits.
- cfg_stall_o  out  1  cfg_valid_i && !cfg_ready_o.

## Operation
- Rule i hits when en[i] && ((addr ^ base[i]) & ~mask[i]) == 0. The lowest index hit wins.
- On a hit, result = (target & ~mask_m) | (addr_m & mask_m). mask_m and addr_m are mask and addr zero-extended or truncated to MstAddrWidth.
- On a miss, result = addr zero-extended or truncated to MstAddrWidth, and miss_o = 1.
- Each channel has an independent two-state FSM, IDLE and HOLD:
  - IDLE: the address output is the combinational result. If valid && !ready: capture result and miss into the hold registers and go to HOLD. If valid && ready: stay IDLE (zero-cycle handshake).
  - HOLD: the address output and miss_o come from the hold registers, regardless of any change on slv_addr_i. On ready: go to IDLE. If valid drops without ready (protocol violation), stay in HOLD; a simulation assertion flags this.
- cfg_ready_o = both FSMs IDLE && !slv_aw_valid_i && !slv_ar_valid_i. This keeps the table stable while any translated address is visible downstream.
- On cfg_valid_i && cfg_ready_o, rule cfg_idx_i is written. It takes effect from the next cycle.
- Rewriting a rule replaces all of its fields.
- An index ≥ NumRules is accepted and ignored.
- When cfg_valid_i and an address valid coincide, the address wins and cfg_ready_o = 0. Configuration can starve under continuous traffic; cfg_stall_o lets upstream throttle.

## Timing
- Reset values:
  - All rules: en = 0, base/mask/target = 0.
  - Both FSMs: IDLE.
  - Hold registers: 0.
  - Outputs: mst_*_addr_o = zero-extended slv_*_addr_i (combinational miss path), miss_o = 1, cfg_ready_o = 1 if no valid, cfg_stall_o = 0.
- Translation latency is 0 cycles (combinational) in IDLE; the output is held from the cycle after the first stalled valid.
- The output value never changes between valid assertion and the ready handshake.
- A configuration write becomes visible one cycle after acceptance.
- Reset asserted mid-HOLD: immediate return to IDLE and the table is cleared; the pending beat is lost.
- No combinational path from mst_*_ready_i to mst_*_addr_o.

## Structure
- Package axi_remap_pkg holds the rule-count limit (16) and the FSM state enum.
- Rule struct: defined locally, because it is parameterized by widths.
- Sub-module axi_remap_hold: per-channel FSM plus hold registers (address, miss), instantiated twice. The rule table and matcher stay in the top module.
- Matcher: a function evaluated once per channel.

## Test plan
- Reset, then AW 0x0000_1234 valid with ready = 1 → mst_aw_addr_o = 0x0000_1234, aw_miss_o = 1, handshake in the same cycle.
- Rule 0 = {en 1, base 0x8000_0000, mask 0x0FFF_FFFF, target 0x4000_0000}; AR 0x8123_4567 → 0x4123_4567, ar_miss_o = 0.
- Rules 0 and 1 both match 0x8000_0010 with targets 0x1…/0x2… → rule 0 result; disable rule 0 → rule 1 result the cycle after the write.
- AW valid with ready low for 5 cycles while slv_aw_addr_i toggles → mst_aw_addr_o constant; cfg_valid_i held → cfg_ready_o = 0, cfg_stall_o = 1 throughout; config accepted the cycle after the handshake with both valids low.
- AW and AR stalled simultaneously with different rules, AR ready first → AR returns to IDLE while AW stays held; no cross-channel corruption.
- rst_i pulsed during AR HOLD → FSM IDLE, all rules disabled, miss_o = 1 immediately (asynchronous).

Source files
------------

// File: rtl/axi_remap_pkg.sv
// Shared definitions for the AXI address-remap controller: the rule-count
// limit and the per-channel FSM state encoding.
package axi_remap_pkg;

  // Largest rule table the controller can be built with.
  localparam int unsigned MaxRules = 16;

  // Per-channel hold FSM: IDLE passes the translated address straight
  // through, HOLD replays the address captured when the master stalled.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } remap_state_e;

endpackage

// File: rtl/axi_addr_remap_ctrl_if.sv
// Signal bundle for the address-remap controller: slave-side AW/AR address
// observation, master-side translated addresses, the configuration write
// port, and debug visibility of both channel FSMs.
//
// Handshake semantics (AW, AR and cfg alike): a transfer happens on a rising
// edge where valid and ready are both high. Once valid is raised it must stay
// high, with its payload stable, until that edge. Ready may depend on valid;
// valid must never depend on ready.
interface axi_addr_remap_ctrl_if
  import axi_remap_pkg::*;
#(
  parameter int unsigned NumRules     = 4,
  parameter int unsigned SlvAddrWidth = 32,
  parameter int unsigned MstAddrWidth = 32
);

  localparam int unsigned IdxWidth = (NumRules > 1) ? $clog2(NumRules) : 1;

  logic [SlvAddrWidth-1:0] slv_aw_addr_i;
  logic                    slv_aw_valid_i;
  logic                    mst_aw_ready_i;
  logic [MstAddrWidth-1:0] mst_aw_addr_o;
  logic                    aw_miss_o;

  logic [SlvAddrWidth-1:0] slv_ar_addr_i;
  logic                    slv_ar_valid_i;
  logic                    mst_ar_ready_i;
  logic [MstAddrWidth-1:0] mst_ar_addr_o;
  logic                    ar_miss_o;

  logic                    cfg_valid_i;
  logic                    cfg_ready_o;
  logic [IdxWidth-1:0]     cfg_idx_i;
  logic                    cfg_en_i;
  logic [SlvAddrWidth-1:0] cfg_base_i;
  logic [SlvAddrWidth-1:0] cfg_mask_i;
  logic [MstAddrWidth-1:0] cfg_target_i;
  logic                    cfg_stall_o;

  // Debug view of the channel FSMs.
  remap_state_e            aw_state;
  remap_state_e            ar_state;

  // Controller side.
  modport slave (
    input  slv_aw_addr_i, slv_aw_valid_i, mst_aw_ready_i,
    input  slv_ar_addr_i, slv_ar_valid_i, mst_ar_ready_i,
    input  cfg_valid_i, cfg_idx_i, cfg_en_i, cfg_base_i, cfg_mask_i, cfg_target_i,
    output mst_aw_addr_o, aw_miss_o, mst_ar_addr_o, ar_miss_o,
    output cfg_ready_o, cfg_stall_o, aw_state, ar_state
  );

  // Environment side (address stage, configuration agent).
  modport master (
    output slv_aw_addr_i, slv_aw_valid_i, mst_aw_ready_i,
    output slv_ar_addr_i, slv_ar_valid_i, mst_ar_ready_i,
    output cfg_valid_i, cfg_idx_i, cfg_en_i, cfg_base_i, cfg_mask_i, cfg_target_i,
    input  mst_aw_addr_o, aw_miss_o, mst_ar_addr_o, ar_miss_o,
    input  cfg_ready_o, cfg_stall_o, aw_state, ar_state
  );

endinterface

// File: rtl/axi_remap_hold.sv
// Per-channel hold stage: passes the translated address through while idle
// and freezes it (with its miss flag) from the first stalled valid until the
// master-side ready handshake.
module axi_remap_hold
  import axi_remap_pkg::*;
#(
  parameter int unsigned AddrWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  input  logic                 ready_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic                 miss_i,
  output logic [AddrWidth-1:0] addr_o,
  output logic                 miss_o,
  output remap_state_e         state_o
);

  remap_state_e         state_q, state_d;
  logic                 capture;
  logic [AddrWidth-1:0] hold_addr_q;
  logic                 hold_miss_q;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state: a stalled valid enters HOLD, ready releases it.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid_i && !ready_i) begin
          capture = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Hold registers load only on the stalled-valid edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_addr_q <= '0;
      hold_miss_q <= 1'b0;
    end else if (capture) begin
      hold_addr_q <= addr_i;
      hold_miss_q <= miss_i;
    end
  end

  // Output mux selected by state only, so ready never reaches the address.
  always_comb begin
    addr_o = addr_i;
    miss_o = miss_i;
    if (state_q == ST_HOLD) begin
      addr_o = hold_addr_q;
      miss_o = hold_miss_q;
    end
  end

  assign state_o = state_q;

`ifndef SYNTHESIS
  hold_valid_kept: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == ST_HOLD) |-> valid_i)
    else $error("axi_remap_hold: valid dropped before ready while holding an address");
`endif

endmodule

// File: rtl/axi_addr_remap_ctrl.sv
// Address-remap controller: a runtime-writable rule table translates the
// slave-port AW/AR addresses; each channel holds its result stable until the
// master handshake. Table writes are only admitted while nothing is pending.
module axi_addr_remap_ctrl
  import axi_remap_pkg::*;
#(
  parameter int unsigned NumRules     = 4,
  parameter int unsigned SlvAddrWidth = 32,
  parameter int unsigned MstAddrWidth = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  axi_addr_remap_ctrl_if.slave  bus
);

  if (NumRules == 0 || NumRules > MaxRules) begin : g_bad_num_rules
    $error("axi_addr_remap_ctrl: NumRules must be within 1..16");
  end

  typedef struct packed {
    logic                    en;
    logic [SlvAddrWidth-1:0] base;
    logic [SlvAddrWidth-1:0] mask;
    logic [MstAddrWidth-1:0] target;
  } rule_t;

  typedef struct packed {
    logic                    miss;
    logic [MstAddrWidth-1:0] addr;
  } xlat_t;

  rule_t        rules_q [NumRules];
  xlat_t        aw_xlat, ar_xlat;
  remap_state_e aw_state, ar_state;
  logic         cfg_ready;
  logic         cfg_fire;

  // Lowest-index enabled rule whose unmasked bits equal its base wins;
  // masked bits pass through from the slave address, the rest come from target.
  function automatic xlat_t translate(input logic [SlvAddrWidth-1:0] addr);
    xlat_t                   res;
    logic [MstAddrWidth-1:0] mask_m;
    res.miss = 1'b1;
    res.addr = MstAddrWidth'(addr);
    mask_m   = '0;
    for (int i = int'(NumRules) - 1; i >= 0; i--) begin
      if (rules_q[i].en && (((addr ^ rules_q[i].base) & ~rules_q[i].mask) == '0)) begin
        mask_m   = MstAddrWidth'(rules_q[i].mask);
        res.miss = 1'b0;
        res.addr = (rules_q[i].target & ~mask_m) | (MstAddrWidth'(addr) & mask_m);
      end
    end
    return res;
  endfunction

  // One matcher evaluation per channel.
  always_comb begin
    aw_xlat = translate(bus.slv_aw_addr_i);
    ar_xlat = translate(bus.slv_ar_addr_i);
  end

  // The table may change only while no translated address is visible.
  assign cfg_ready = (aw_state == ST_IDLE) && (ar_state == ST_IDLE) &&
                     !bus.slv_aw_valid_i && !bus.slv_ar_valid_i;
  assign cfg_fire  = bus.cfg_valid_i && cfg_ready;

  // Rule table: whole-rule overwrite; out-of-range indices are dropped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NumRules); i++) rules_q[i] <= '0;
    end else if (cfg_fire && (32'(bus.cfg_idx_i) < NumRules)) begin
      rules_q[bus.cfg_idx_i] <= rule_t'{
        en:     bus.cfg_en_i,
        base:   bus.cfg_base_i,
        mask:   bus.cfg_mask_i,
        target: bus.cfg_target_i
      };
    end
  end

  axi_remap_hold #(.AddrWidth(MstAddrWidth)) u_aw_hold (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (bus.slv_aw_valid_i),
    .ready_i (bus.mst_aw_ready_i),
    .addr_i  (aw_xlat.addr),
    .miss_i  (aw_xlat.miss),
    .addr_o  (bus.mst_aw_addr_o),
    .miss_o  (bus.aw_miss_o),
    .state_o (aw_state)
  );

  axi_remap_hold #(.AddrWidth(MstAddrWidth)) u_ar_hold (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (bus.slv_ar_valid_i),
    .ready_i (bus.mst_ar_ready_i),
    .addr_i  (ar_xlat.addr),
    .miss_i  (ar_xlat.miss),
    .addr_o  (bus.mst_ar_addr_o),
    .miss_o  (bus.ar_miss_o),
    .state_o (ar_state)
  );

  assign bus.cfg_ready_o = cfg_ready;
  assign bus.cfg_stall_o = bus.cfg_valid_i && !cfg_ready;
  assign bus.aw_state    = aw_state;
  assign bus.ar_state    = ar_state;

endmodule

// File: tb/tb_axi_addr_remap_ctrl.sv
// Directed bench for axi_addr_remap_ctrl: queued expected beats checked on
// every master handshake, plus point checks of hold, config gating and reset.
module tb_axi_addr_remap_ctrl;
  import axi_remap_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned SW = 32;
  localparam int unsigned MW = 32;
  localparam int unsigned IW = 2;
  localparam int unsigned EW = MW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_addr_remap_ctrl_if #(.NumRules(NR), .SlvAddrWidth(SW), .MstAddrWidth(MW)) bus ();

  axi_addr_remap_ctrl #(.NumRules(NR), .SlvAddrWidth(SW), .MstAddrWidth(MW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [EW-1:0] exp_aw_q[$];
  logic [EW-1:0] exp_ar_q[$];

  logic          m_en     [NR];
  logic [SW-1:0] m_base   [NR];
  logic [SW-1:0] m_mask   [NR];
  logic [MW-1:0] m_target [NR];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: scan rules in priority order, first match decides.
  function automatic logic [EW-1:0] model(input logic [SW-1:0] a);
    for (int i = 0; i < NR; i++) begin
      if (m_en[i] && ((a & ~m_mask[i]) == (m_base[i] & ~m_mask[i])))
        return {1'b0, (m_target[i] & ~m_mask[i]) | (a & m_mask[i])};
    end
    return {1'b1, a};
  endfunction

  // Every master handshake pops one expected beat per channel.
  always @(negedge clk) begin
    if (!rst && bus.slv_aw_valid_i && bus.mst_aw_ready_i) begin
      check("aw_queue_underflow", 64'(exp_aw_q.size() == 0), 64'd0);
      if (exp_aw_q.size() != 0)
        check("aw_beat", {bus.aw_miss_o, bus.mst_aw_addr_o}, exp_aw_q.pop_front());
    end
    if (!rst && bus.slv_ar_valid_i && bus.mst_ar_ready_i) begin
      check("ar_queue_underflow", 64'(exp_ar_q.size() == 0), 64'd0);
      if (exp_ar_q.size() != 0)
        check("ar_beat", {bus.ar_miss_o, bus.mst_ar_addr_o}, exp_ar_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int idx, input logic en, input logic [SW-1:0] base,
                           input logic [SW-1:0] mask, input logic [MW-1:0] target);
    bus.cfg_valid_i  = 1'b1;
    bus.cfg_idx_i    = IW'(idx);
    bus.cfg_en_i     = en;
    bus.cfg_base_i   = base;
    bus.cfg_mask_i   = mask;
    bus.cfg_target_i = target;
    #2 check("cfg_ready_on_write", bus.cfg_ready_o, 1);
    tick();
    bus.cfg_valid_i = 1'b0;
    if (idx < NR) begin
      m_en[idx] = en; m_base[idx] = base; m_mask[idx] = mask; m_target[idx] = target;
    end
  endtask

  task automatic aw_beat(input logic [SW-1:0] a, input logic [EW-1:0] exp);
    bus.slv_aw_addr_i = a; bus.slv_aw_valid_i = 1'b1; bus.mst_aw_ready_i = 1'b1;
    exp_aw_q.push_back(exp);
    #2 check("aw_comb", {bus.aw_miss_o, bus.mst_aw_addr_o}, exp);
    tick();
    bus.slv_aw_valid_i = 1'b0; bus.mst_aw_ready_i = 1'b0;
    check("aw_idle_after_beat", bus.aw_state, ST_IDLE);
  endtask

  task automatic ar_beat(input logic [SW-1:0] a, input logic [EW-1:0] exp);
    bus.slv_ar_addr_i = a; bus.slv_ar_valid_i = 1'b1; bus.mst_ar_ready_i = 1'b1;
    exp_ar_q.push_back(exp);
    #2 check("ar_comb", {bus.ar_miss_o, bus.mst_ar_addr_o}, exp);
    tick();
    bus.slv_ar_valid_i = 1'b0; bus.mst_ar_ready_i = 1'b0;
    check("ar_idle_after_beat", bus.ar_state, ST_IDLE);
  endtask

  // ---------------- directed sequence ----------------
  logic [SW-1:0] a;

  initial begin
    rst = 1'b1;
    bus.slv_aw_addr_i = '0; bus.slv_aw_valid_i = 1'b0; bus.mst_aw_ready_i = 1'b0;
    bus.slv_ar_addr_i = '0; bus.slv_ar_valid_i = 1'b0; bus.mst_ar_ready_i = 1'b0;
    bus.cfg_valid_i = 1'b0; bus.cfg_idx_i = '0; bus.cfg_en_i = 1'b0;
    bus.cfg_base_i = '0; bus.cfg_mask_i = '0; bus.cfg_target_i = '0;
    for (int i = 0; i < NR; i++) begin
      m_en[i] = 1'b0; m_base[i] = '0; m_mask[i] = '0; m_target[i] = '0;
    end

    // Reset state.
    #2;
    bus.slv_aw_addr_i = 32'h0000_0055;
    #1;
    check("rst_aw_addr", bus.mst_aw_addr_o, 32'h0000_0055);
    check("rst_aw_miss", bus.aw_miss_o, 1);
    check("rst_ar_miss", bus.ar_miss_o, 1);
    check("rst_cfg_ready", bus.cfg_ready_o, 1);
    check("rst_cfg_stall", bus.cfg_stall_o, 0);
    check("rst_aw_state", bus.aw_state, ST_IDLE);
    check("rst_ar_state", bus.ar_state, ST_IDLE);
    tick();
    rst = 1'b0;

    // Miss path with zero-cycle handshake.
    aw_beat(32'h0000_1234, {1'b1, 32'h0000_1234});

    // Single rule on AR.
    cfg_write(0, 1'b1, 32'h8000_0000, 32'h0FFF_FFFF, 32'h4000_0000);
    ar_beat(32'h8123_4567, {1'b0, 32'h4123_4567});

    // Two overlapping rules: lowest index wins, then disable rule 0.
    cfg_write(0, 1'b1, 32'h8000_0000, 32'h0000_00FF, 32'h1000_0000);
    cfg_write(1, 1'b1, 32'h8000_0000, 32'h0000_FFFF, 32'h2000_0000);
    aw_beat(32'h8000_0010, {1'b0, 32'h1000_0010});
    bus.cfg_valid_i = 1'b1; bus.cfg_idx_i = 2'd0; bus.cfg_en_i = 1'b0;
    bus.cfg_base_i = '0; bus.cfg_mask_i = '0; bus.cfg_target_i = '0;
    #2;
    check("disable_write_ready", bus.cfg_ready_o, 1);
    check("table_unchanged_same_cycle", bus.mst_aw_addr_o, 32'h1000_0010);
    tick();
    bus.cfg_valid_i = 1'b0;
    m_en[0] = 1'b0; m_base[0] = '0; m_mask[0] = '0; m_target[0] = '0;
    check("table_updated_next_cycle", {bus.aw_miss_o, bus.mst_aw_addr_o}, {1'b0, 32'h2000_0010});
    aw_beat(32'h8000_0010, {1'b0, 32'h2000_0010});

    // AW stalled 5 cycles with toggling address, config held off meanwhile.
    bus.slv_aw_addr_i = 32'h8000_0010; bus.slv_aw_valid_i = 1'b1; bus.mst_aw_ready_i = 1'b0;
    exp_aw_q.push_back({1'b0, 32'h2000_0010});
    bus.cfg_valid_i = 1'b1; bus.cfg_idx_i = 2'd2; bus.cfg_en_i = 1'b1;
    bus.cfg_base_i = 32'h9000_0000; bus.cfg_mask_i = 32'h0FFF_FFFF; bus.cfg_target_i = 32'h3000_0000;
    #2;
    check("stall0_addr", bus.mst_aw_addr_o, 32'h2000_0010);
    check("stall0_cfg_ready", bus.cfg_ready_o, 0);
    check("stall0_cfg_stall", bus.cfg_stall_o, 1);
    for (int c = 0; c < 5; c++) begin
      tick();
      bus.slv_aw_addr_i = $urandom();
      #1;
      check("stall_state", bus.aw_state, ST_HOLD);
      check("stall_addr", {bus.aw_miss_o, bus.mst_aw_addr_o}, {1'b0, 32'h2000_0010});
      check("stall_cfg_ready", bus.cfg_ready_o, 0);
      check("stall_cfg_stall", bus.cfg_stall_o, 1);
    end
    bus.mst_aw_ready_i = 1'b1;
    #1 check("handshake_cfg_ready", bus.cfg_ready_o, 0);
    tick();
    bus.slv_aw_valid_i = 1'b0; bus.mst_aw_ready_i = 1'b0;
    #1;
    check("post_hs_cfg_ready", bus.cfg_ready_o, 1);
    check("post_hs_cfg_stall", bus.cfg_stall_o, 0);
    tick();
    bus.cfg_valid_i = 1'b0;
    m_en[2] = 1'b1; m_base[2] = 32'h9000_0000; m_mask[2] = 32'h0FFF_FFFF; m_target[2] = 32'h3000_0000;
    ar_beat(32'h9ABC_DEF0, {1'b0, 32'h3ABC_DEF0});

    // AW and AR stalled together, AR released first.
    bus.slv_aw_addr_i = 32'h8000_0010; bus.slv_aw_valid_i = 1'b1; bus.mst_aw_ready_i = 1'b0;
    bus.slv_ar_addr_i = 32'h9000_0004; bus.slv_ar_valid_i = 1'b1; bus.mst_ar_ready_i = 1'b0;
    exp_aw_q.push_back({1'b0, 32'h2000_0010});
    exp_ar_q.push_back({1'b0, 32'h3000_0004});
    tick();
    bus.slv_aw_addr_i = '0; bus.slv_ar_addr_i = '0;
    #1;
    check("dual_aw_hold", {bus.aw_miss_o, bus.mst_aw_addr_o}, {1'b0, 32'h2000_0010});
    check("dual_ar_hold", {bus.ar_miss_o, bus.mst_ar_addr_o}, {1'b0, 32'h3000_0004});
    bus.mst_ar_ready_i = 1'b1;
    tick();
    bus.slv_ar_valid_i = 1'b0; bus.mst_ar_ready_i = 1'b0; bus.slv_ar_addr_i = 32'h0000_0ABC;
    #1;
    check("dual_ar_state", bus.ar_state, ST_IDLE);
    check("dual_aw_state", bus.aw_state, ST_HOLD);
    check("dual_ar_comb", {bus.ar_miss_o, bus.mst_ar_addr_o}, {1'b1, 32'h0000_0ABC});
    check("dual_aw_still_held", {bus.aw_miss_o, bus.mst_aw_addr_o}, {1'b0, 32'h2000_0010});
    bus.mst_aw_ready_i = 1'b1;
    tick();
    bus.slv_aw_valid_i = 1'b0; bus.mst_aw_ready_i = 1'b0;
    check("dual_aw_released", bus.aw_state, ST_IDLE);

    // Asynchronous reset during AR HOLD.
    bus.slv_ar_addr_i = 32'h8000_0010; bus.slv_ar_valid_i = 1'b1; bus.mst_ar_ready_i = 1'b0;
    tick();
    bus.slv_ar_addr_i = 32'h8000_0077;
    #1;
    check("pre_rst_ar_state", bus.ar_state, ST_HOLD);
    check("pre_rst_ar_hold", {bus.ar_miss_o, bus.mst_ar_addr_o}, {1'b0, 32'h2000_0010});
    rst = 1'b1;
    #1;
    check("rst_async_ar_state", bus.ar_state, ST_IDLE);
    check("rst_async_ar_out", {bus.ar_miss_o, bus.mst_ar_addr_o}, {1'b1, 32'h8000_0077});
    bus.slv_ar_valid_i = 1'b0;
    for (int i = 0; i < NR; i++) m_en[i] = 1'b0;
    tick();
    rst = 1'b0;
    aw_beat(32'h9000_0004, {1'b1, 32'h9000_0004});
    ar_beat(32'h8000_0010, {1'b1, 32'h8000_0010});

    // Randomised traffic against two overlapping rules.
    cfg_write(0, 1'b1, 32'hA000_0000, 32'h00FF_FFFF, 32'h5500_0000);
    cfg_write(3, 1'b1, 32'hA000_0000, 32'h0FFF_FFFF, 32'h6600_0000);
    for (int k = 0; k < 8; k++) begin
      a = $urandom();
      case ($urandom_range(0, 3))
        0, 1:    a[31:28] = 4'hA;
        2:       a[31:28] = 4'hB;
        default: a[31:28] = 4'h0;
      endcase
      if ($urandom_range(0, 1) == 1) a[27:24] = 4'h0;
      if (k[0]) aw_beat(a, model(a));
      else      ar_beat(a, model(a));
    end

    tick();
    tick();
    check("aw_queue_drained", 64'(exp_aw_q.size()), 64'd0);
    check("ar_queue_drained", 64'(exp_ar_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
